// File: rtl/slave_rx_pkg.sv
// Shared definitions for the I2C write-only slave receiver.
//   state_e            : receiver FSM states
//   SLAVE_ADDR_DEFAULT : 7-bit address answered when not overridden
//   I2C_RW_WRITE       : value of the R/W bit for a master write
//   addr_hit()         : address byte decode (7-bit match and write direction)
package slave_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } state_e;

    localparam logic [6:0] SLAVE_ADDR_DEFAULT = 7'h2A;
    localparam logic       I2C_RW_WRITE       = 1'b0;

    // Address byte is {addr[6:0], rw}; only writes to our address are accepted.
    function automatic logic addr_hit(input logic [7:0] b, input logic [6:0] addr);
        return (b[7:1] == addr) && (b[0] == I2C_RW_WRITE);
    endfunction

endpackage

// File: rtl/rx_word_fifo2.sv
// Two-entry word buffer, FIFO order.
//   clk, rst_n : clock, async active-low reset
//   push_i     : write data_i (accepted when not full, or when full and popping)
//   data_i     : word to store
//   pop_i      : consume the head entry (ignored when empty)
//   data_o     : head entry, forced to 0 while empty
//   full_o     : both entries occupied
//   empty_o    : no entry occupied
module rx_word_fifo2 #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [1:0][WORD_W-1:0] mem_q;
    logic                   wr_q;
    logic                   rd_q;
    logic [1:0]             cnt_q;
    logic                   push_ok;
    logic                   pop_ok;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign pop_ok  = pop_i && !empty_o;
    // When full, the write slot is the slot being popped, so a same-cycle
    // pop makes room: the head is read combinationally before the edge.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ~wr_q;
            end
            if (pop_ok) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/slave_rx.sv
// I2C slave receiver: decodes start/stop, matches a 7-bit write address,
// assembles WORD_W-bit words MSB-first and buffers them two deep.
//   clk, rst_n : system clock, async active-low reset
//   SCL, SDA   : bus clock/data from the master (asynchronous, synchronized here)
//   AckOut     : 1 = ACK to the master during the acknowledge bit
//   RXData     : oldest buffered word (0 when none)
//   RXValid    : RXData holds a valid word
//   RXReady    : consumer takes RXData this cycle
//   Busy       : addressed transaction in progress
//   Overflow   : sticky, a completed word was dropped (cleared only by reset)
//   OvfCount   : saturating dropped-word count, present only when the macro
//                SLAVE_RX_OVF_CNT_EN is defined
// WORD_W must be a multiple of 8.
module slave_rx
    import slave_rx_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = SLAVE_ADDR_DEFAULT,
    parameter int         WORD_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SCL,
    input  logic              SDA,
    output logic              AckOut,
    output logic [WORD_W-1:0] RXData,
    output logic              RXValid,
    input  logic              RXReady,
    output logic              Busy,
    output logic              Overflow
`ifdef SLAVE_RX_OVF_CNT_EN
    ,
    output logic [7:0]        OvfCount
`endif
);

    localparam int NBYTES = WORD_W / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

    // Synchronizers reset to 1 (idle bus) so reset release never looks like
    // a start condition.
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_s, sda_s;
    logic       start_c, stop_c, scl_rise, scl_fall;

    state_e             state_q, state_d;
    logic [2:0]         bitcnt_q, bitcnt_d;
    logic [BCW-1:0]     bytecnt_q, bytecnt_d;
    logic [6:0]         shreg_q, shreg_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               ack_q, ack_d;
    logic               ackph_q, ackph_d;   // first falling edge of the ack slot seen
    logic               nack_q, nack_d;     // this ack slot must NACK (word dropped)
    logic               ovf_q;

    logic [7:0]         byte_v;
    logic [WORD_W-1:0]  word_v;
    logic               push, drop, pop;
    logic               fifo_full, fifo_empty;

    assign scl_s    = scl_sync_q[1];
    assign sda_s    = sda_sync_q[1];
    assign start_c  = scl_s && sda_prev_q && !sda_s;
    assign stop_c   = scl_s && !sda_prev_q && sda_s;
    assign scl_rise = scl_s && !scl_prev_q;
    assign scl_fall = !scl_s && scl_prev_q;

    assign byte_v = {shreg_q, sda_s};
    assign word_v = (word_q << 8) | WORD_W'(byte_v);
    assign pop    = RXValid && RXReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], SCL};
            sda_sync_q <= {sda_sync_q[0], SDA};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bitcnt_q  <= '0;
            bytecnt_q <= '0;
            shreg_q   <= '0;
            word_q    <= '0;
            ack_q     <= 1'b0;
            ackph_q   <= 1'b0;
            nack_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            bytecnt_q <= bytecnt_d;
            shreg_q   <= shreg_d;
            word_q    <= word_d;
            ack_q     <= ack_d;
            ackph_q   <= ackph_d;
            nack_q    <= nack_d;
            ovf_q     <= ovf_q | drop;
        end
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        bytecnt_d = bytecnt_q;
        shreg_d   = shreg_q;
        word_d    = word_q;
        ack_d     = ack_q;
        ackph_d   = ackph_q;
        nack_d    = nack_q;
        push      = 1'b0;
        drop      = 1'b0;

        case (state_q)
            ST_ADDR: begin
                if (scl_rise) begin
                    shreg_d  = byte_v[6:0];
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = addr_hit(byte_v, SLAVE_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                        ackph_d = 1'b0;
                        nack_d  = 1'b0;
                    end
                end
            end
            ST_ADDR_ACK, ST_DATA_ACK: begin
                // Drive the ack bit from the falling edge after the 8th bit
                // to the falling edge after the 9th.
                if (scl_fall) begin
                    if (!ackph_q) begin
                        ackph_d = 1'b1;
                        ack_d   = !nack_q;
                    end else begin
                        ackph_d  = 1'b0;
                        ack_d    = 1'b0;
                        nack_d   = 1'b0;
                        bitcnt_d = '0;
                        state_d  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (scl_rise) begin
                    shreg_d  = byte_v[6:0];
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        word_d  = word_v;
                        state_d = ST_DATA_ACK;
                        ackph_d = 1'b0;
                        if (bytecnt_q == LAST_BYTE) begin
                            bytecnt_d = '0;
                            if (!fifo_full || pop) begin
                                push = 1'b1;
                            end else begin
                                // No room: lose the word and NACK its last byte;
                                // the ack slot is still tracked so bit timing
                                // stays aligned with the master.
                                drop   = 1'b1;
                                nack_d = 1'b1;
                            end
                        end else begin
                            bytecnt_d = bytecnt_q + 1'b1;
                        end
                    end
                end
            end
            default: ;  // ST_IDLE, ST_IGNORE wait for start/stop
        endcase

        if (stop_c || start_c) begin
            state_d   = start_c ? ST_ADDR : ST_IDLE;
            bitcnt_d  = '0;
            bytecnt_d = '0;
            shreg_d   = '0;
            word_d    = '0;
            ack_d     = 1'b0;
            ackph_d   = 1'b0;
            nack_d    = 1'b0;
        end
    end

    rx_word_fifo2 #(.WORD_W(WORD_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (word_v),
        .pop_i   (pop),
        .data_o  (RXData),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign RXValid  = !fifo_empty;
    assign AckOut   = ack_q;
    assign Overflow = ovf_q;
    assign Busy     = (state_q == ST_ADDR_ACK) || (state_q == ST_DATA) ||
                      (state_q == ST_DATA_ACK);

`ifdef SLAVE_RX_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= 8'd0;
        end else if (drop && ovf_cnt_q != 8'hFF) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign OvfCount = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_slave_rx.sv
// Bench for slave_rx: table of bus transactions plus hand-written sequences
// for buffer-full, overflow and mid-transaction reset. Received words are
// checked against a scoreboard queue filled when stimulus is driven.
module tb_slave_rx;

    localparam int H = 4;  // SCL half-period in clk cycles

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SCL = 1'b1;
    logic        SDA = 1'b1;
    logic        RXReady = 1'b0;
    logic        AckOut;
    logic [31:0] RXData;
    logic        RXValid;
    logic        Busy;
    logic        Overflow;
`ifdef SLAVE_RX_OVF_CNT_EN
    logic [7:0]  OvfCount;
`endif

    slave_rx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SCL      (SCL),
        .SDA      (SDA),
        .AckOut   (AckOut),
        .RXData   (RXData),
        .RXValid  (RXValid),
        .RXReady  (RXReady),
        .Busy     (Busy),
        .Overflow (Overflow)
`ifdef SLAVE_RX_OVF_CNT_EN
        ,
        .OvfCount (OvfCount)
`endif
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] sb_q[$];
    logic [31:0] sb_exp;
    bit          busy_seen;
    int          stray;

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        int          nbytes;
        logic [31:0] data;      // bytes sent MSB first
        int          exp_acks;  // address + data bytes ACKed
        bit          exp_word;  // a word should be delivered
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every transfer (RXValid & RXReady) must match the next queued word.
    always @(negedge clk) begin
        if (Busy) busy_seen = 1'b1;
        if (rst_n && RXValid && RXReady) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL rx_unexpected: got %08h, no word expected", RXData);
            end else begin
                sb_exp = sb_q.pop_front();
                if (RXData !== sb_exp) begin
                    fails++;
                    $display("FAIL rx_word: got %08h expected %08h", RXData, sb_exp);
                end
            end
        end
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        SDA = 1'b1; wait_clk(H);
        SCL = 1'b1; wait_clk(H);
        SDA = 1'b0; wait_clk(H);
        SCL = 1'b0; wait_clk(H);
    endtask

    task automatic i2c_stop();
        SDA = 1'b0; wait_clk(H);
        SCL = 1'b1; wait_clk(H);
        SDA = 1'b1; wait_clk(H);
    endtask

    // pulse: raise RXReady for exactly the cycle in which the slave samples
    // this bit (2-flop sync + edge detect puts that 3 edges after SCL rises).
    task automatic i2c_bit(input logic b, input bit pulse);
        SDA = b; wait_clk(H);
        SCL = 1'b1;
        if (pulse) begin
            wait_clk(2); RXReady = 1'b1;
            wait_clk(1); RXReady = 1'b0;
            wait_clk(1);
        end else begin
            wait_clk(2);
            if (AckOut) stray++;
            wait_clk(2);
        end
        SCL = 1'b0; wait_clk(H);
    endtask

    task automatic i2c_byte(input logic [7:0] b, input bit pulse_last, output bit ack);
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], pulse_last && (i == 0));
        SDA = 1'b1; wait_clk(H);
        SCL = 1'b1; wait_clk(2);
        ack = AckOut;
        wait_clk(2);
        SCL = 1'b0; wait_clk(H);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int acks;
        bit a;
        logic [31:0] d;
        acks = 0;
        stray = 0;
        busy_seen = 1'b0;
        d = v.data;
        if (v.exp_word) sb_q.push_back(v.data);
        i2c_start();
        i2c_byte({v.addr, v.rw}, 1'b0, a);
        acks += int'(a);
        for (int i = 0; i < v.nbytes; i++) begin
            i2c_byte(d[31-8*i -: 8], 1'b0, a);
            acks += int'(a);
        end
        i2c_stop();
        wait_clk(6);
        chk({tag, "_acks"}, 32'(acks), 32'(v.exp_acks));
        chk({tag, "_stray_ack"}, 32'(stray), 32'd0);
        chk({tag, "_busy_seen"}, {31'd0, busy_seen}, {31'd0, v.exp_acks > 0});
        chk({tag, "_rxvalid_after"}, {31'd0, RXValid}, 32'd0);
    endtask

    initial begin
        bit a;
        int acks;
        logic [31:0] w;
        logic [31:0] words[3];

        vecs[0] = '{7'h2A, 1'b0, 4, 32'hDEADBEEF, 5, 1'b1};
        vecs[1] = '{7'h2B, 1'b0, 4, 32'hCAFEF00D, 0, 1'b0};
        vecs[2] = '{7'h2A, 1'b1, 4, 32'h12345678, 0, 1'b0};
        vecs[3] = '{7'h2A, 1'b0, 2, 32'hAABB0000, 3, 1'b0};
        vecs[4] = '{7'h2A, 1'b0, 4, 32'h01020304, 5, 1'b1};
        vecs[5] = '{7'h2A, 1'b0, 4, 32'h00FF807F, 5, 1'b1};

        // Reset state
        wait_clk(3);
        chk("rst_ackout",   {31'd0, AckOut},   32'd0);
        chk("rst_rxvalid",  {31'd0, RXValid},  32'd0);
        chk("rst_rxdata",   RXData,            32'd0);
        chk("rst_busy",     {31'd0, Busy},     32'd0);
        chk("rst_overflow", {31'd0, Overflow}, 32'd0);
        rst_n = 1'b1;
        wait_clk(4);

        // Table of transactions, consumer always ready
        RXReady = 1'b1;
        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        chk("table_sb_empty", 32'(sb_q.size()), 32'd0);

        // Both buffers full, word completes in the same cycle as a pop
        RXReady = 1'b0;
        words = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
        acks = 0;
        i2c_start();
        i2c_byte({7'h2A, 1'b0}, 1'b0, a);
        acks += int'(a);
        for (int k = 0; k < 3; k++) begin
            w = words[k];
            sb_q.push_back(w);
            for (int i = 0; i < 4; i++) begin
                i2c_byte(w[31-8*i -: 8], (k == 2) && (i == 3), a);
                acks += int'(a);
            end
        end
        i2c_stop();
        wait_clk(4);
        chk("simul_acks",     32'(acks),         32'd13);
        chk("simul_overflow", {31'd0, Overflow}, 32'd0);
        chk("simul_rxvalid",  {31'd0, RXValid},  32'd1);
        chk("simul_sb_left",  32'(sb_q.size()),  32'd2);
        RXReady = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) wait_clk(1);
        chk("simul_sb_empty", 32'(sb_q.size()), 32'd0);

        // Overflow: three words, nothing consumed
        RXReady = 1'b0;
        wait_clk(2);
        words = '{32'h11111111, 32'h22222222, 32'h33333333};
        sb_q.push_back(words[0]);
        sb_q.push_back(words[1]);
        acks = 0;
        i2c_start();
        i2c_byte({7'h2A, 1'b0}, 1'b0, a);
        acks += int'(a);
        for (int k = 0; k < 3; k++) begin
            w = words[k];
            for (int i = 0; i < 4; i++) begin
                i2c_byte(w[31-8*i -: 8], 1'b0, a);
                if (k == 2 && i == 3) chk("ovf_last_byte_nack", {31'd0, a}, 32'd0);
                else acks += int'(a);
            end
        end
        i2c_stop();
        wait_clk(4);
        chk("ovf_acks",     32'(acks),         32'd12);
        chk("ovf_overflow", {31'd0, Overflow}, 32'd1);
        chk("ovf_rxvalid",  {31'd0, RXValid},  32'd1);
        chk("ovf_head",     RXData,            32'h11111111);
`ifdef SLAVE_RX_OVF_CNT_EN
        chk("ovfcnt_1", {24'd0, OvfCount}, 32'd1);
        i2c_start();
        i2c_byte({7'h2A, 1'b0}, 1'b0, a);
        for (int i = 0; i < 8; i++) i2c_byte(8'h44 + 8'(i), 1'b0, a);
        i2c_stop();
        wait_clk(4);
        chk("ovfcnt_3", {24'd0, OvfCount}, 32'd3);
`endif
        RXReady = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) wait_clk(1);
        wait_clk(2);
        chk("ovf_sb_empty",    32'(sb_q.size()),  32'd0);
        chk("ovf_drained",     {31'd0, RXValid},  32'd0);
        chk("ovf_sticky",      {31'd0, Overflow}, 32'd1);

        // Reset in the middle of a data byte, with a word buffered
        RXReady = 1'b0;
        i2c_start();
        i2c_byte({7'h2A, 1'b0}, 1'b0, a);
        for (int i = 0; i < 5; i++) i2c_byte(8'h5A, 1'b0, a);
        for (int i = 0; i < 4; i++) i2c_bit(1'b1, 1'b0);
        chk("pre_rst_busy",    {31'd0, Busy},    32'd1);
        chk("pre_rst_rxvalid", {31'd0, RXValid}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_rxvalid",  {31'd0, RXValid},  32'd0);
        chk("mid_rst_rxdata",   RXData,            32'd0);
        chk("mid_rst_busy",     {31'd0, Busy},     32'd0);
        chk("mid_rst_ackout",   {31'd0, AckOut},   32'd0);
        chk("mid_rst_overflow", {31'd0, Overflow}, 32'd0);
        wait_clk(2);
        SCL = 1'b1;
        SDA = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        RXReady = 1'b1;
        run_vec(vecs[0], "post_rst");

        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
